// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared state type and frame constants for fifo_uart_tx
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS_NO_PARITY = 10;
    localparam int FRAME_BITS_PARITY    = 11;

`ifdef PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
    localparam int FRAME_BITS = FRAME_BITS_NO_PARITY;
`endif

    function automatic int frame_cycles(input int clks_per_bit);
        return FRAME_BITS * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// rtl/fifo_uart_tx_baud_tick_gen.sv - bit-time down-counter; tick while the count sits at zero
module baud_tick_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_reload,
    output logic o_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    // Parks at zero between frames so the FSM only has to reload on bit boundaries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_reload) begin
            r_count <= RELOAD_VAL;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_tick = (r_count == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter draining a 16x8 FIFO; define PARITY_EN for an even-parity bit
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_fifo_empty,
    input  logic [DATA_BITS-1:0] i_fifo_dout,
    output logic                 o_fifo_rd_en,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    state_t               r_state, w_state_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_rd_en, w_rd_en_nxt;
    logic                 r_busy, w_busy_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_nxt;
    logic                 w_reload;
    logic                 w_tick;
`ifdef PARITY_EN
    logic                 r_parity, w_parity_nxt;
`endif

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .i_reload(w_reload),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_shift   <= '0;
            r_bit_idx <= '0;
`ifdef PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_tx      <= w_tx_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_busy    <= w_busy_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
`ifdef PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
        end
    end

    // tx is registered one bit ahead: each transition loads the level of the bit that follows.
    always_comb begin
        w_state_nxt   = r_state;
        w_tx_nxt      = r_tx;
        w_rd_en_nxt   = 1'b0;
        w_busy_nxt    = r_busy;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_reload      = 1'b0;
`ifdef PARITY_EN
        w_parity_nxt  = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (!i_fifo_empty) begin
                    w_state_nxt = POP;
                    w_rd_en_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            POP: begin
                w_state_nxt = LOAD;
            end
            LOAD: begin
                w_shift_nxt = i_fifo_dout;
                w_tx_nxt    = 1'b0;
                w_reload    = 1'b1;
                w_state_nxt = START;
`ifdef PARITY_EN
                w_parity_nxt = ^i_fifo_dout;
`endif
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                    w_reload      = 1'b1;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_reload = 1'b1;
                    if (r_bit_idx == LAST_IDX) begin
`ifdef PARITY_EN
                        w_state_nxt = PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                        w_shift_nxt   = r_shift >> 1;
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                    w_reload    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_tx_nxt = 1'b1;
                    if (!i_fifo_empty) begin
                        w_state_nxt = POP;
                        w_rd_en_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign o_fifo_rd_en = r_rd_en;
    assign o_tx         = r_tx;
    assign o_busy       = r_busy;
    assign o_tx_done    = (r_state == STOP) && w_tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - randomized and directed bench for fifo_uart_tx against a frame-level model
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef PARITY_EN
    localparam int NB     = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NB     = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FLEN = 2 + NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en, tx, busy, tx_done;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    int n_assert = 0;
    int n_fail = 0;
    int pop_empty_err = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int busy_low = 0;
    bit drain_win = 1'b0;
    bit check_en = 1'b0;

    logic [7:0] fq[$];
    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    int         m_off = 0;
    int         m_pre = 0;
    logic [7:0] m_byte = 8'h00;
    logic [3:0] e_vec;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_fifo_empty(fifo_empty),
        .i_fifo_dout (fifo_dout),
        .o_fifo_rd_en(fifo_rd_en),
        .o_tx        (tx),
        .o_busy      (busy),
        .o_tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Expected line level at cycle offset j of a frame whose pop cycle is offset 0.
    function automatic logic exp_tx(input logic [7:0] b, input int j);
        int k;
        if (j < 2) return 1'b1;
        k = (j - 2) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && PAR_EN) return ^b;
        return 1'b1;
    endfunction

    // Synchronous 16x8 FIFO with registered read data.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() == 0) pop_empty_err++;
            else fifo_dout <= fq.pop_front();
        end
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    // Frame-level model: a frame starts on any edge where it is free and bytes are waiting.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            m_off    = 0;
        end else begin
            m_pre = mq.size();
            if (m_active && m_off < FLEN - 1) begin
                m_off++;
            end else if (m_pre > 0) begin
                m_active = 1'b1;
                m_off    = 0;
                m_byte   = mq.pop_front();
            end else begin
                m_active = 1'b0;
            end
            if (wr_en) mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (fifo_rd_en) rd_cnt++;
        if (tx_done) done_cnt++;
        if (drain_win && !busy) busy_low++;
        if (check_en) begin
            if (m_active && rst)
                e_vec = {exp_tx(m_byte, m_off), 1'b1, m_off == 0, m_off == FLEN - 1};
            else
                e_vec = 4'b1000;
            check("cycle_tx_busy_rd_done", int'({tx, busy, fifo_rd_en, tx_done}), int'(e_vec));
        end
    end

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic decode(output logic [7:0] b, output logic par, output logic stp);
        int w;
        b = 8'h00; par = 1'b0; stp = 1'b0; w = 0;
        while (tx !== 1'b0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("start_bit_seen", int'(tx), 0);
        if (tx !== 1'b0) return;
        repeat (CPB / 2) @(negedge clk);
        check("start_bit_mid", int'(tx), 0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
`ifdef PARITY_EN
        repeat (CPB) @(negedge clk);
        par = tx;
`endif
        repeat (CPB) @(negedge clk);
        stp = tx;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (tx_done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("tx_done_seen", int'(tx_done), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       p, s;
        int         k, g, n_pushed;

        check("model_start", int'(exp_tx(8'hA5, 2)), 0);
        check("model_bit0", int'(exp_tx(8'hA5, 2 + CPB)), 1);
        check("model_bit1", int'(exp_tx(8'hA5, 2 + 2 * CPB)), 0);
        check("model_bit7", int'(exp_tx(8'hA5, 2 + 9 * CPB - 1)), 1);
        check("model_stop", int'(exp_tx(8'hA5, 2 + NB * CPB - 1)), 1);
        check("model_pop_gap", int'(exp_tx(8'h00, 1)), 1);
`ifdef PARITY_EN
        check("model_par_07", int'(exp_tx(8'h07, 2 + 9 * CPB)), 1);
        check("model_par_03", int'(exp_tx(8'h03, 2 + 9 * CPB)), 0);
`endif

        // Reset held for 3 cycles, then 50 idle cycles with an empty FIFO.
        rst = 1'b0;
        @(negedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("reset_state", int'({tx, busy, fifo_rd_en, tx_done}), 4'b1000);
        repeat (50) @(negedge clk);
        check("idle_no_pop", rd_cnt, 0);

        // Single byte 0xA5.
        rd_cnt = 0; done_cnt = 0;
        push(8'hA5);
        decode(b, p, s);
        check("a5_data", int'(b), 8'hA5);
        check("a5_stop", int'(s), 1);
`ifdef PARITY_EN
        check("a5_parity", int'(p), 0);
`endif
        wait_done(k);
        check("a5_frame_len", CPB / 2 + CPB * (NB - 1) + k + 1, NB * CPB);
        repeat (10) @(negedge clk);
        check("a5_pop_count", rd_cnt, 1);
        check("a5_done_count", done_cnt, 1);
        check("a5_busy_end", int'(busy), 0);

        // Full drain of 15 bytes written back to back.
        rd_cnt = 0; busy_low = 0;
        fork
            begin
                for (int i = 0; i < 15; i++) begin
                    wr_en   = 1'b1;
                    wr_data = 8'(i);
                    @(negedge clk);
                end
                wr_en = 1'b0;
            end
            begin
                for (int i = 0; i < 15; i++) begin
                    logic [7:0] db;
                    logic       dp, ds;
                    decode(db, dp, ds);
                    if (i == 0) drain_win = 1'b1;
                    check("drain_data", int'(db), i);
                    check("drain_stop", int'(ds), 1);
                end
                drain_win = 1'b0;
            end
        join
        check("drain_busy_held", busy_low, 0);
        wait_done(k);
        repeat (5) @(negedge clk);
        check("drain_fifo_empty", int'(fifo_empty), 1);
        check("drain_pop_count", rd_cnt, 15);
        check("drain_no_empty_pop", pop_empty_err, 0);

`ifdef PARITY_EN
        push(8'h07);
        decode(b, p, s);
        check("par07_data", int'(b), 8'h07);
        check("par07_parity", int'(p), 1);
        push(8'h03);
        decode(b, p, s);
        check("par03_data", int'(b), 8'h03);
        check("par03_parity", int'(p), 0);
        wait_done(k);
        repeat (5) @(negedge clk);
`endif

        // Reset during data bit 3 of 0x55; 0x66 stays queued.
        push(8'h55);
        push(8'h66);
        g = 0;
        while (tx !== 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("rst55_start_seen", int'(tx), 0);
        repeat (4 * CPB + 1) @(negedge clk);
        check("rst55_bit3_low", int'(tx), 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_tx_immediate", int'(tx), 1);
        check("rst_busy_immediate", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        decode(b, p, s);
        check("after_rst_data", int'(b), 8'h66);
        check("after_rst_stop", int'(s), 1);
        wait_done(k);
        repeat (5) @(negedge clk);

        // Late arrival: next byte written during the stop bit of the previous frame.
        push(8'h3C);
        decode(b, p, s);
        check("late_first_data", int'(b), 8'h3C);
        push(8'hC3);
        wait_done(k);
        check("late_push_in_stop", k, 0);
        g = 0;
        while (tx !== 1'b0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("late_gap_cycles", g, 3);
        decode(b, p, s);
        check("late_second_data", int'(b), 8'hC3);
        wait_done(k);
        repeat (5) @(negedge clk);

        // Randomized traffic; the per-cycle compare carries the checking.
        n_pushed = 0; done_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0 && fq.size() < 14) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                n_pushed++;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        g = 0;
        while ((!fifo_empty || busy) && g < 4000) begin
            @(negedge clk);
            g++;
        end
        check("random_drained", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("random_frame_count", done_cnt, n_pushed);
        check("final_no_empty_pop", pop_empty_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
